// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 execute stage: ALU ops, forwarding selects,
// branch conditions and the iterative multiplier state machine.
package riscv_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLT  = 4'h5,
      ALU_SLTU = 4'h6,
      ALU_SLL  = 4'h7,
      ALU_SRL  = 4'h8,
      ALU_SRA  = 4'h9,
      ALU_LUI  = 4'hA,
      ALU_MUL  = 4'hB
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_RF2 = 2'b11
   } fwd_sel_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Shift-and-add multiplier: one partial product per cycle, XLEN iterations,
// low XLEN bits of the product presented in the DONE state.
module mul_iter
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   mul_state_e      state_q;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mplr_q;
   logic [CW-1:0]   cnt_q;

   // Busy covers the issue cycle too, so the stall takes effect immediately.
   always_comb begin
      busy_o = 1'b0;
      if (state_q == MUL_BUSY) begin
         busy_o = 1'b1;
      end else if (state_q == MUL_IDLE) begin
         busy_o = start_i;
      end else begin
         busy_o = 1'b0;
      end
   end

   assign done_o   = (state_q == MUL_DONE);
   assign result_o = acc_q;

   // Multiplier state machine and datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MUL_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (start_i) begin
                  mcand_q <= a_i;
                  mplr_q  <= b_i;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               acc_q   <= acc_q + (mplr_q[0] ? mcand_q : '0);
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               state_q <= MUL_IDLE;
            end
            default: begin
               state_q <= MUL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/datapath_ex.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution,
// iterative multiplier and the EX/MEM pipeline register.
module datapath_ex
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWriteE,
   input  logic [1:0]      ResultSrcE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            BranchE,
   input  logic [3:0]      ALUControlE,
   input  logic            ALUSrcE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [4:0]      RdE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            BusyE,
   output logic            RegWriteM,
   output logic [1:0]      ResultSrcM,
   output logic            MemWriteM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RdM
);

   logic [XLEN-1:0] src_a_s, write_data_s, src_b_s, alu_result_s;
   logic [XLEN-1:0] jalr_sum_s, mul_result_s;
   logic            taken_s, mul_busy_s, mul_done_s;

   logic            reg_write_d, reg_write_q, mem_write_d, mem_write_q;
   logic [1:0]      result_src_d, result_src_q;
   logic [XLEN-1:0] alu_result_d, alu_result_q, write_data_d, write_data_q;
   logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
   logic [4:0]      rd_d, rd_q;

   // Operand forwarding; codes 00 and 11 both select the register file.
   always_comb begin
      src_a_s      = RD1E;
      write_data_s = RD2E;
      case (ForwardAE)
         FWD_WB:          src_a_s = ResultW;
         FWD_MEM:         src_a_s = alu_result_q;
         FWD_RF, FWD_RF2: src_a_s = RD1E;
         default:         src_a_s = RD1E;
      endcase
      case (ForwardBE)
         FWD_WB:          write_data_s = ResultW;
         FWD_MEM:         write_data_s = alu_result_q;
         FWD_RF, FWD_RF2: write_data_s = RD2E;
         default:         write_data_s = RD2E;
      endcase
   end

   assign src_b_s = ALUSrcE ? ImmExtE : write_data_s;

   mul_iter #(.XLEN(XLEN)) u_mul (
      .clk      (clk),
      .reset    (reset),
      .start_i  (ALUControlE == ALU_MUL),
      .a_i      (src_a_s),
      .b_i      (src_b_s),
      .busy_o   (mul_busy_s),
      .done_o   (mul_done_s),
      .result_o (mul_result_s)
   );

   assign BusyE = mul_busy_s;

   // ALU; the MUL slot only carries a value once the multiplier has finished.
   always_comb begin
      alu_result_s = '0;
      case (ALUControlE)
         ALU_ADD:  alu_result_s = src_a_s + src_b_s;
         ALU_SUB:  alu_result_s = src_a_s - src_b_s;
         ALU_AND:  alu_result_s = src_a_s & src_b_s;
         ALU_OR:   alu_result_s = src_a_s | src_b_s;
         ALU_XOR:  alu_result_s = src_a_s ^ src_b_s;
         ALU_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
         ALU_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
         ALU_SLL:  alu_result_s = src_a_s << src_b_s[4:0];
         ALU_SRL:  alu_result_s = src_a_s >> src_b_s[4:0];
         ALU_SRA:  alu_result_s = $unsigned($signed(src_a_s) >>> src_b_s[4:0]);
         ALU_LUI:  alu_result_s = src_b_s;
         ALU_MUL:  alu_result_s = mul_done_s ? mul_result_s : '0;
         default:  alu_result_s = '0;
      endcase
   end

   // Branch condition compares rs1 against forwarded rs2, never the immediate.
   always_comb begin
      taken_s = 1'b0;
      case (funct3E)
         F3_BEQ:  taken_s = (src_a_s == write_data_s);
         F3_BNE:  taken_s = (src_a_s != write_data_s);
         F3_BLT:  taken_s = ($signed(src_a_s) <  $signed(write_data_s));
         F3_BGE:  taken_s = ($signed(src_a_s) >= $signed(write_data_s));
         F3_BLTU: taken_s = (src_a_s <  write_data_s);
         F3_BGEU: taken_s = (src_a_s >= write_data_s);
         default: taken_s = 1'b0;
      endcase
   end

   assign jalr_sum_s = src_a_s + ImmExtE;
   assign PCSrcE     = JumpE | (BranchE & taken_s);
   assign PCTargetE  = JalrE ? {jalr_sum_s[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

   // EX/MEM next state: a bubble while the multiplier holds the stage.
   always_comb begin
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      mem_write_d  = 1'b0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
      rd_d         = 5'd0;
      if (BusyE) begin
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
      end else begin
         reg_write_d  = RegWriteE;
         result_src_d = ResultSrcE;
         mem_write_d  = MemWriteE;
         alu_result_d = alu_result_s;
         write_data_d = write_data_s;
         pc_plus4_d   = PCPlus4E;
         rd_d         = RdE;
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         mem_write_q  <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
         rd_q         <= 5'd0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         mem_write_q  <= mem_write_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
      end
   end

   assign RegWriteM  = reg_write_q;
   assign ResultSrcM = result_src_q;
   assign MemWriteM  = mem_write_q;
   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign PCPlus4M   = pc_plus4_q;
   assign RdM        = rd_q;

endmodule

// File: tb/tb_datapath_ex.sv
// Directed bench for datapath_ex: ALU ops, forwarding, branches, jumps,
// multiplier latency/bubbles and reset during a multiply.
module tb_datapath_ex;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic [3:0]  ALUControlE;
   logic [2:0]  funct3E;
   logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
   logic [4:0]  RdE;
   logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;

   int total = 0;
   int bad   = 0;

   datapath_ex dut (
      .clk(clk), .reset(reset),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .funct3E(funct3E),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .ImmExtE(ImmExtE), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit reached, got timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      RegWriteE = 1'b0; ResultSrcE = 2'b00; MemWriteE = 1'b0;
      JumpE = 1'b0; JalrE = 1'b0; BranchE = 1'b0;
      ALUControlE = 4'h0; ALUSrcE = 1'b0; funct3E = 3'b000;
      RD1E = 32'h0; RD2E = 32'h0; PCE = 32'h0; PCPlus4E = 32'h0;
      ImmExtE = 32'h0; RdE = 5'd0; ForwardAE = 2'b00; ForwardBE = 2'b00;
      ResultW = 32'h0;
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
      clr();
      ALUControlE = op; RD1E = a; RD2E = b;
      tick();
      chk(tag, ALUResultM, exp);
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      int  n;
      bit  bub_ok;
      n = 0;
      bub_ok = 1'b1;
      clr();
      ALUControlE = 4'hB; RD1E = a; RD2E = b; RegWriteE = 1'b1;
      RdE = 5'd9; PCPlus4E = 32'h44;
      #1;
      while (BusyE === 1'b1 && n < 100) begin
         n++;
         tick();
         if (RegWriteM !== 1'b0 || RdM !== 5'd0 || ALUResultM !== 32'h0 || PCPlus4M !== 32'h0)
            bub_ok = 1'b0;
      end
      chk({tag, "_busy_cycles"}, n, 32'd33);
      chk({tag, "_bubbles"}, 32'(bub_ok), 32'd1);
      tick();
      chk({tag, "_result"}, ALUResultM, exp);
      chk({tag, "_rd"}, 32'(RdM), 32'd9);
      chk({tag, "_regwrite"}, 32'(RegWriteM), 32'd1);
      clr();
      #1;
      chk({tag, "_idle_after"}, 32'(BusyE), 32'd0);
      tick();
      chk({tag, "_once"}, ALUResultM, 32'h0);
   endtask

   initial begin
      clr();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_alu", ALUResultM, 32'h0);
      chk("rst_regwrite", 32'(RegWriteM), 32'd0);
      chk("rst_busy", 32'(BusyE), 32'd0);
      chk("rst_pcsrc", 32'(PCSrcE), 32'd0);
      chk("rst_target", PCTargetE, 32'h0);

      // Plain ADD with control pass-through.
      clr();
      RD1E = 32'd5; RD2E = 32'd7; RegWriteE = 1'b1; RdE = 5'd3;
      tick();
      chk("add", ALUResultM, 32'd12);
      chk("add_rd", 32'(RdM), 32'd3);
      chk("add_regwrite", 32'(RegWriteM), 32'd1);

      // Forwarding from MEM and WB.
      clr();
      RD1E = 32'd100;
      tick();
      chk("pre_fwd", ALUResultM, 32'd100);
      clr();
      ForwardAE = 2'b10; ImmExtE = 32'hFFFF_FFFF; ALUSrcE = 1'b1;
      tick();
      chk("fwd_mem", ALUResultM, 32'd99);
      clr();
      ForwardAE = 2'b01; ResultW = 32'd50; ImmExtE = 32'd5; ALUSrcE = 1'b1;
      tick();
      chk("fwd_wb", ALUResultM, 32'd55);
      clr();
      ForwardBE = 2'b01; ResultW = 32'h33; MemWriteE = 1'b1; RD2E = 32'h77;
      tick();
      chk("fwd_b_alu", ALUResultM, 32'h33);
      chk("fwd_b_wdata", WriteDataM, 32'h33);
      chk("fwd_b_memwrite", 32'(MemWriteM), 32'd1);

      // ALU operations.
      alu(4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
      alu(4'h2, 32'hF0F0, 32'hFF00, 32'hF000, "and");
      alu(4'h3, 32'hF0F0, 32'hFF00, 32'hFFF0, "or");
      alu(4'h4, 32'hF0F0, 32'hFF00, 32'h0FF0, "xor");
      alu(4'h5, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
      alu(4'h6, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
      alu(4'h7, 32'd1, 32'd31, 32'h8000_0000, "sll");
      alu(4'h8, 32'h8000_0000, 32'h24, 32'h0800_0000, "srl");
      alu(4'h9, 32'h8000_0000, 32'h24, 32'hF800_0000, "sra");
      alu(4'hA, 32'h1, 32'h1234_5000, 32'h1234_5000, "lui");
      alu(4'hC, 32'd3, 32'd4, 32'h0, "op_c");
      alu(4'h0, 32'hFFFF_FFFF, 32'd2, 32'd1, "add_wrap");

      // Branch resolution.
      clr();
      RD1E = 32'hFFFF_FFFD; RD2E = 32'd2; funct3E = 3'b100; BranchE = 1'b1;
      PCE = 32'h40; ImmExtE = 32'h10; ALUSrcE = 1'b1;
      #1;
      chk("blt_taken", 32'(PCSrcE), 32'd1);
      chk("blt_target", PCTargetE, 32'h50);
      funct3E = 3'b110;
      #1;
      chk("bltu_not", 32'(PCSrcE), 32'd0);
      funct3E = 3'b101;
      #1;
      chk("bge_not", 32'(PCSrcE), 32'd0);
      funct3E = 3'b010;
      RD2E = 32'hFFFF_FFFD;
      #1;
      chk("f3_010_never", 32'(PCSrcE), 32'd0);
      funct3E = 3'b000;
      #1;
      chk("beq_taken", 32'(PCSrcE), 32'd1);

      // JALR and JAL.
      clr();
      JumpE = 1'b1; JalrE = 1'b1; RD1E = 32'h1003; PCE = 32'h2000;
      PCPlus4E = 32'h2004; RegWriteE = 1'b1; RdE = 5'd1;
      #1;
      chk("jalr_pcsrc", 32'(PCSrcE), 32'd1);
      chk("jalr_target", PCTargetE, 32'h1002);
      tick();
      chk("jalr_link", PCPlus4M, 32'h2004);
      clr();
      JumpE = 1'b1; PCE = 32'h2000; ImmExtE = 32'h100;
      #1;
      chk("jal_target", PCTargetE, 32'h2100);

      // Multiplier.
      do_mul(32'd7, 32'd6, 32'd42, "mul7x6");
      do_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mulneg");

      // Reset in the middle of a multiply.
      clr();
      ALUControlE = 4'hB; RD1E = 32'd5; RD2E = 32'd5; RegWriteE = 1'b1; RdE = 5'd4;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_mul_busy", 32'(BusyE), 32'd1);
      clr();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mul_busy", 32'(BusyE), 32'd0);
      chk("rst_mul_alu", ALUResultM, 32'h0);
      chk("rst_mul_regwrite", 32'(RegWriteM), 32'd0);
      chk("rst_mul_rd", 32'(RdM), 32'd0);
      do_mul(32'd3, 32'd3, 32'd9, "mul3x3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
